// File: rtl/hsync_gen.sv
// hsync_gen: horizontal timing generator with line counter, blank, sync and end-of-line strobe.
// Define HSYNC_GEN_RUNTIME_CFG_EN to build shadow timing registers applied at line end.
`timescale 1ns/1ps
module hsync_gen #(
    parameter int CNT_W       = 9,
    parameter int H_TOTAL     = 455,
    parameter int HBLANK_END  = 80,
    parameter int HSYNC_START = 32,
    parameter int HSYNC_END   = 64
) (
    input  logic             mclk,
    input  logic             _reset,
    input  logic             ce,
    input  logic             cfg_wr,
    input  logic [1:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_data,
    output logic [CNT_W-1:0] hcnt,
    output logic             hblank,
    output logic             _hblank,
    output logic             _hsync,
    output logic             hreset,
    output logic             cfg_pending,
    output logic             cfg_err
);
    localparam logic [CNT_W-1:0] T0  = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] BE0 = CNT_W'(HBLANK_END);
    localparam logic [CNT_W-1:0] SS0 = CNT_W'(HSYNC_START);
    localparam logic [CNT_W-1:0] SE0 = CNT_W'(HSYNC_END);

    logic [CNT_W-1:0] t, be, ss, se;
    logic [CNT_W-1:0] t_n, be_n, ss_n, se_n;
    logic [CNT_W-1:0] nxt;
    logic             last;

    assign last    = hcnt == t - 1'b1;
    assign nxt     = last ? '0 : hcnt + 1'b1;
    assign _hblank = ~hblank;

`ifdef HSYNC_GEN_RUNTIME_CFG_EN
    logic [CNT_W-1:0] sh_t, sh_be, sh_se, sh_ss;
    logic             apply, valid, apply_ok;

    assign apply    = ce && last && cfg_pending;
    assign valid    = sh_t >= CNT_W'(2) && sh_ss < sh_se && sh_se <= sh_be && sh_be <= sh_t;
    assign apply_ok = apply && valid;
    // decode for the next count must already see timing applied at this wrap
    assign t_n  = apply_ok ? sh_t  : t;
    assign be_n = apply_ok ? sh_be : be;
    assign ss_n = apply_ok ? sh_ss : ss;
    assign se_n = apply_ok ? sh_se : se;

    always_ff @(posedge mclk or negedge _reset)
        if (!_reset) begin
            t           <= T0;
            be          <= BE0;
            ss          <= SS0;
            se          <= SE0;
            sh_t        <= T0;
            sh_be       <= BE0;
            sh_ss       <= SS0;
            sh_se       <= SE0;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            if (apply_ok) begin
                t  <= sh_t;
                be <= sh_be;
                ss <= sh_ss;
                se <= sh_se;
            end
            if (cfg_wr) begin
                sh_t  <= cfg_sel == 2'd0 ? cfg_data : sh_t;
                sh_be <= cfg_sel == 2'd1 ? cfg_data : sh_be;
                sh_ss <= cfg_sel == 2'd2 ? cfg_data : sh_ss;
                sh_se <= cfg_sel == 2'd3 ? cfg_data : sh_se;
            end
            cfg_pending <= cfg_wr || (cfg_pending && !apply);
            cfg_err     <= apply && !valid;
        end
`else
    logic unused;

    assign unused      = ^{cfg_wr, cfg_sel, cfg_data};
    assign t           = T0;
    assign be          = BE0;
    assign ss          = SS0;
    assign se          = SE0;
    assign t_n         = t;
    assign be_n        = be;
    assign ss_n        = ss;
    assign se_n        = se;
    assign cfg_pending = 1'b0;
    assign cfg_err     = 1'b0;
`endif

    always_ff @(posedge mclk or negedge _reset)
        if (!_reset) begin
            hcnt   <= '0;
            hblank <= 1'b1;
            _hsync <= 1'b1;
            hreset <= 1'b0;
        end else if (ce) begin
            hcnt   <= nxt;
            hblank <= nxt < be_n;
            _hsync <= !(nxt >= ss_n && nxt < se_n && nxt < be_n);
            hreset <= nxt == t_n - 1'b1;
        end
endmodule

// File: tb/tb_hsync_gen.sv
// tb_hsync_gen: directed bench for hsync_gen, default timing plus runtime shadow config when built in.
`timescale 1ns/1ps
module tb_hsync_gen;
`ifdef HSYNC_GEN_RUNTIME_CFG_EN
    localparam bit RT = 1'b1;
`else
    localparam bit RT = 1'b0;
`endif

    logic       mclk = 1'b0;
    logic       _reset = 1'b1;
    logic       ce = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [1:0] cfg_sel = 2'd0;
    logic [8:0] cfg_data = 9'd0;
    logic [8:0] hcnt;
    logic       hblank, _hblank, _hsync, hreset, cfg_pending, cfg_err;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;
    int et = 455, ebe = 80, ess = 32, ese = 64;
    int nt = 455, nbe = 80, nss = 32, nse = 64;
    bit e_pend = 1'b0;
    bit e_err = 1'b0;

    hsync_gen dut (
        .mclk(mclk), ._reset(_reset), .ce(ce),
        .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .hcnt(hcnt), .hblank(hblank), ._hblank(_hblank), ._hsync(_hsync),
        .hreset(hreset), .cfg_pending(cfg_pending), .cfg_err(cfg_err)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at count %0d: observed %0d expected %0d", tag, exp_cnt, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("hcnt", hcnt, exp_cnt);
        chk("hblank", hblank, exp_cnt < ebe);
        chk("_hblank", _hblank, !(exp_cnt < ebe));
        chk("_hsync", _hsync, !(exp_cnt >= ess && exp_cnt < ese && exp_cnt < ebe));
        chk("hreset", hreset, exp_cnt == et - 1);
        chk("cfg_pending", cfg_pending, e_pend);
        chk("cfg_err", cfg_err, e_err);
    endtask

    task automatic tick(input bit swap);
        ce = 1'b1;
        @(posedge mclk);
        #1;
        exp_cnt = (exp_cnt == et - 1) ? 0 : exp_cnt + 1;
        if (swap) begin
            et = nt; ebe = nbe; ess = nss; ese = nse;
        end
        chk_all();
    endtask

    task automatic hold();
        ce = 1'b0;
        @(posedge mclk);
        #1;
        chk_all();
    endtask

    task automatic run_to(input int target);
        while (exp_cnt != target) tick(1'b0);
    endtask

    task automatic wr(input logic [1:0] sel, input int data);
        cfg_wr = 1'b1;
        cfg_sel = sel;
        cfg_data = 9'(data);
        e_pend = RT;
        tick(1'b0);
        cfg_wr = 1'b0;
    endtask

    initial begin
        // asynchronous reset, no clock edge needed
        #2 _reset = 1'b0;
        #1 chk_all();
        repeat (2) @(posedge mclk);
        #1 chk_all();
        _reset = 1'b1;
        // two full default lines, ce every cycle
        for (int i = 0; i < 910; i++) tick(1'b0);
        // ce every third mclk, outputs frozen in between
        for (int i = 0; i < 460; i++) begin
            tick(1'b0);
            hold();
            hold();
        end
        // reset mid-line discards a pending write
        run_to(150);
        wr(2'd0, 300);
        run_to(200);
        #2 _reset = 1'b0;
        #1;
        exp_cnt = 0;
        e_pend = 1'b0;
        e_err = 1'b0;
        chk_all();
        @(posedge mclk);
        #1 chk_all();
        _reset = 1'b1;
        for (int i = 0; i < 455; i++) tick(1'b0);
        if (RT) begin
            // valid reconfiguration applied at line end
            run_to(100);
            wr(2'd0, 100);
            wr(2'd1, 20);
            wr(2'd2, 4);
            wr(2'd3, 10);
            run_to(454);
            nt = 100; nbe = 20; nss = 4; nse = 10;
            e_pend = 1'b0;
            tick(1'b1);
            for (int i = 0; i < 100; i++) tick(1'b0);
            // invalid ordering rejected, timing unchanged
            wr(2'd2, 30);
            wr(2'd3, 20);
            run_to(99);
            e_pend = 1'b0;
            e_err = 1'b1;
            tick(1'b0);
            e_err = 1'b0;
            hold();
            // write on the apply cycle lands one line later
            wr(2'd2, 2);
            run_to(99);
            cfg_wr = 1'b1;
            cfg_sel = 2'd3;
            cfg_data = 9'd8;
            nt = 100; nbe = 20; nss = 2; nse = 20;
            tick(1'b1);
            cfg_wr = 1'b0;
            run_to(99);
            nse = 8;
            e_pend = 1'b0;
            tick(1'b1);
            for (int i = 0; i < 100; i++) tick(1'b0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
